// File: rtl/cart_mem_arb.sv
// Cartridge-memory arbiter: shares one memory port between the cartridge bus
// controller (port 0, fixed priority) and the loader/save-state engine (port 1).
// One transaction is in flight at a time. A starvation counter forces port 1
// after STARVE_MAX consecutive port-0 grants made while port 1 was waiting.
module cart_mem_arb #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic [21:1] P0_A,
  input  logic [15:0] P0_DO,
  input  logic [1:0]  P0_WE,
  input  logic        P0_RD,
  output logic [15:0] P0_DI,
  output logic        P0_RDY,
  input  logic [21:1] P1_A,
  input  logic [15:0] P1_DO,
  input  logic [1:0]  P1_WE,
  input  logic        P1_RD,
  output logic [15:0] P1_DI,
  output logic        P1_RDY,
  output logic [21:1] MEM_A,
  output logic [15:0] MEM_DO,
  output logic [1:0]  MEM_WE,
  output logic        MEM_RD,
  input  logic [15:0] MEM_DI,
  input  logic        MEM_RDY
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t      state, state_nxt;
  logic        owner;
  logic [7:0]  starve;
  logic        req0, req1;
  logic        grant, grant_p1;
  logic [21:1] sel_a;
  logic [15:0] sel_do;
  logic [1:0]  sel_we;
  logic        sel_rd;

  // Request decode and winner selection for the IDLE grant decision
  always_comb begin
    req0     = P0_RD | (|P0_WE);
    req1     = P1_RD | (|P1_WE);
    grant_p1 = req1 & (~req0 | (starve == STARVE_LIM));
    grant    = (state == IDLE) & EN & (req0 | req1);
    sel_a    = grant_p1 ? P1_A  : P0_A;
    sel_do   = grant_p1 ? P1_DO : P0_DO;
    sel_we   = grant_p1 ? P1_WE : P0_WE;
    sel_rd   = grant_p1 ? P1_RD : P0_RD;
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: DONE always lasts exactly one cycle and never samples requests
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)   state_nxt = BUSY;
      BUSY:    if (MEM_RDY) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side strobes, owner tracking and per-port completion/read data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner  <= 1'b0;
      MEM_A  <= '0;
      MEM_DO <= '0;
      MEM_WE <= '0;
      MEM_RD <= 1'b0;
      P0_DI  <= '0;
      P1_DI  <= '0;
      P0_RDY <= 1'b0;
      P1_RDY <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner  <= grant_p1;
          MEM_A  <= sel_a;
          MEM_DO <= sel_do;
          MEM_WE <= sel_we;
          MEM_RD <= sel_rd & ~(|sel_we);
        end
        BUSY: if (MEM_RDY) begin
          MEM_WE <= '0;
          MEM_RD <= 1'b0;
          // MEM_WE still holds the granted strobes here, so it tells read from write
          if (owner) begin
            P1_RDY <= 1'b1;
            if (MEM_WE == 2'b00) P1_DI <= MEM_DI;
          end else begin
            P0_RDY <= 1'b1;
            if (MEM_WE == 2'b00) P0_DI <= MEM_DI;
          end
        end
        DONE: begin
          P0_RDY <= 1'b0;
          P1_RDY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts port-0 grants made while port 1 waits
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (!req1)
        starve <= '0;
      else if (grant && grant_p1)
        starve <= '0;
      else if (grant && starve != STARVE_LIM)
        starve <= starve + 8'd1;
    end
  end

endmodule

// File: tb/tb_cart_mem_arb.sv
// Directed bench for cart_mem_arb: reset, single read, byte write, contention
// ordering, no-regrant, EN gating and mid-transaction reset.
module tb_cart_mem_arb;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic [21:1] P0_A, P1_A;
  logic [15:0] P0_DO, P1_DO;
  logic [1:0]  P0_WE, P1_WE;
  logic        P0_RD, P1_RD;
  logic [15:0] P0_DI, P1_DI;
  logic        P0_RDY, P1_RDY;
  logic [21:1] MEM_A;
  logic [15:0] MEM_DO;
  logic [1:0]  MEM_WE;
  logic        MEM_RD;
  logic [15:0] MEM_DI;
  logic        MEM_RDY;

  int unsigned passed = 0;
  int unsigned total  = 0;

  cart_mem_arb #(.STARVE_MAX(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN),
    .P0_A(P0_A), .P0_DO(P0_DO), .P0_WE(P0_WE), .P0_RD(P0_RD),
    .P0_DI(P0_DI), .P0_RDY(P0_RDY),
    .P1_A(P1_A), .P1_DO(P1_DO), .P1_WE(P1_WE), .P1_RD(P1_RD),
    .P1_DI(P1_DI), .P1_RDY(P1_RDY),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD),
    .MEM_DI(MEM_DI), .MEM_RDY(MEM_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b1;
    P0_A = '0; P0_DO = '0; P0_WE = '0; P0_RD = 1'b0;
    P1_A = '0; P1_DO = '0; P1_WE = '0; P1_RD = 1'b0;
    MEM_DI = '0; MEM_RDY = 1'b0;
    #1;
    chk("rst_mem_rd", 32'(MEM_RD), 0);
    chk("rst_mem_we", 32'(MEM_WE), 0);
    chk("rst_mem_a",  32'(MEM_A), 0);
    chk("rst_mem_do", 32'(MEM_DO), 0);
    chk("rst_p0_di",  32'(P0_DI), 0);
    chk("rst_p1_di",  32'(P1_DI), 0);
    chk("rst_rdy",    32'({P0_RDY, P1_RDY}), 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Single read on port 0, memory answers after 4 cycles
    P0_RD = 1'b1; P0_A = 21'h00123;
    tick();
    chk("rd_mem_rd", 32'(MEM_RD), 1);
    chk("rd_mem_a",  32'(MEM_A), 32'h00123);
    tick(); tick(); tick();
    chk("rd_hold", 32'({MEM_RD, P0_RDY}), 32'b10);
    MEM_RDY = 1'b1; MEM_DI = 16'hBEEF;
    tick();
    MEM_RDY = 1'b0; MEM_DI = 16'h0000;
    chk("rd_p0_rdy", 32'(P0_RDY), 1);
    chk("rd_p0_di",  32'(P0_DI), 32'hBEEF);
    chk("rd_p1_rdy", 32'(P1_RDY), 0);
    chk("rd_mem_rd_drop", 32'(MEM_RD), 0);
    // Requester still holds P0_RD through the DONE cycle; no re-grant expected
    tick();
    P0_RD = 1'b0;
    chk("norg_rdy_pulse", 32'(P0_RDY), 0);
    chk("norg_mem_rd0", 32'(MEM_RD), 0);
    tick();
    chk("norg_mem_rd1", 32'(MEM_RD), 0);

    // Byte write on port 1 with RD also raised
    P1_WE = 2'b10; P1_RD = 1'b1; P1_DO = 16'h5A00; P1_A = 21'h0ABCD;
    tick();
    chk("wr_mem_we", 32'(MEM_WE), 32'b10);
    chk("wr_mem_rd", 32'(MEM_RD), 0);
    chk("wr_mem_do", 32'(MEM_DO), 32'h5A00);
    chk("wr_mem_a",  32'(MEM_A), 32'h0ABCD);
    MEM_RDY = 1'b1; MEM_DI = 16'h1234;
    tick();
    MEM_RDY = 1'b0;
    chk("wr_p1_rdy", 32'(P1_RDY), 1);
    chk("wr_p1_di",  32'(P1_DI), 0);
    chk("wr_p0_hold", 32'({P0_RDY, P0_DI}), 32'h0BEEF);
    chk("wr_mem_we_drop", 32'(MEM_WE), 0);
    P1_WE = '0; P1_RD = 1'b0;
    tick();

    // Contention: both ports continuously requesting; order P0 x8, P1, P0 x8, P1
    P0_RD = 1'b1; P0_A = 21'h00100;
    P1_RD = 1'b1; P1_A = 21'h00200;
    for (int i = 0; i < 18; i++) begin
      logic exp_p1;
      exp_p1 = (i % 9 == 8);
      tick();
      chk($sformatf("cont_grant_%0d", i), 32'(MEM_A), exp_p1 ? 32'h00200 : 32'h00100);
      MEM_RDY = 1'b1;
      tick();
      MEM_RDY = 1'b0;
      chk($sformatf("cont_rdy_%0d", i), 32'({P0_RDY, P1_RDY}), exp_p1 ? 32'b01 : 32'b10);
      tick();
    end
    P0_RD = 1'b0; P1_RD = 1'b0;
    tick();

    // EN dropped while BUSY: current transaction completes, P1 waits for EN
    P0_RD = 1'b1; P0_A = 21'h00300;
    tick();
    chk("en_grant_p0", 32'({MEM_RD, MEM_A}), {1'b1, 21'h00300});
    EN = 1'b0; P1_RD = 1'b1; P1_A = 21'h00400;
    MEM_RDY = 1'b1; MEM_DI = 16'h7777;
    tick();
    MEM_RDY = 1'b0;
    chk("en_p0_rdy", 32'(P0_RDY), 1);
    chk("en_p0_di", 32'(P0_DI), 32'h7777);
    tick();
    P0_RD = 1'b0;
    tick(); tick();
    chk("en_blocked", 32'(MEM_RD), 0);
    EN = 1'b1;
    tick();
    chk("en_grant_p1", 32'({MEM_RD, MEM_A}), {1'b1, 21'h00400});
    MEM_RDY = 1'b1; MEM_DI = 16'hCAFE;
    tick();
    MEM_RDY = 1'b0;
    chk("en_p1_rdy", 32'({P0_RDY, P1_RDY}), 32'b01);
    chk("en_p1_di", 32'(P1_DI), 32'hCAFE);
    P1_RD = 1'b0;
    tick();

    // Reset pulse while BUSY, then a late MEM_RDY
    P0_RD = 1'b1; P0_A = 21'h00500;
    tick();
    chk("rst_mid_busy", 32'(MEM_RD), 1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_rd_async", 32'(MEM_RD), 0);
    chk("rst_mid_a_async", 32'(MEM_A), 0);
    P0_RD = 1'b0;
    #2 RST_N = 1'b1;
    MEM_RDY = 1'b1; MEM_DI = 16'h9999;
    tick();
    MEM_RDY = 1'b0;
    chk("rst_late_rdy", 32'({P0_RDY, P1_RDY}), 0);
    chk("rst_late_di", 32'(P0_DI), 0);
    tick();
    P0_RD = 1'b1; P0_A = 21'h00600;
    tick();
    chk("rst_regrant", 32'({MEM_RD, MEM_A}), {1'b1, 21'h00600});
    MEM_RDY = 1'b1; MEM_DI = 16'h1111;
    tick();
    MEM_RDY = 1'b0;
    chk("rst_regrant_rdy", 32'(P0_RDY), 1);
    chk("rst_regrant_di", 32'(P0_DI), 32'h1111);
    P0_RD = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
